// File: rtl/photonic_pkg.sv
// photonic_pkg
//   Shared definitions for the photonic transceiver blocks.
//   tx_state_e : transmit scheduler states. Other transceiver-level blocks
//                may reuse this enum when they need to observe the scheduler.
package photonic_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_SLOT = 2'd1,
    SEND      = 2'd2
  } tx_state_e;

endpackage

// File: rtl/photonic_tx_scheduler_rr_arbiter.sv
// rr_arbiter
//   Combinational round-robin arbiter. It grants the first set bit of
//   `valid` found when scanning upward from index `ptr`, wrapping around to
//   index 0.
// Ports:
//   valid : in  N          request lines
//   ptr   : in  clog2(N)   highest-priority index for this cycle
//   grant : out N          one-hot grant, or zero when nothing is valid
//   found : out 1          a grant was issued
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic [N-1:0]         valid,
  input  logic [$clog2(N)-1:0] ptr,
  output logic [N-1:0]         grant,
  output logic                 found
);

  // Two passes: first the indices at or above ptr, then the ones below it.
  // This gives the wrap-around priority without any modulo arithmetic.
  always_comb begin
    grant = '0;
    found = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (!found && (i >= int'(ptr)) && valid[i]) begin
        grant[i] = 1'b1;
        found    = 1'b1;
      end
    end
    for (int i = 0; i < N; i++) begin
      if (!found && (i < int'(ptr)) && valid[i]) begin
        grant[i] = 1'b1;
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/photonic_tx_scheduler.sv
// photonic_tx_scheduler
//   Shares a node's photonic transmitter between N_REQ local requesters.
//   Packets are placed only in this node's TDM slot on the shared waveguide.
//   At most one packet is sent per slot, and only whole slots are used.
// Ports:
//   clk        : in  1                     rising-edge clock
//   rst        : in  1                     synchronous, active-low reset
//   id         : in  ID_WIDTH              this node's id (static)
//   req_valid  : in  N_REQ                 per-requester packet pending
//   req_dest   : in  N_REQ*ID_WIDTH        destination per requester
//   req_data   : in  N_REQ*DATA_WIDTH      payload per requester
//   req_ready  : out N_REQ                 one-hot grant (IDLE only)
//   tx_enable  : out 1                     transmitter enable
//   tx_dest_id : out ID_WIDTH              destination to transmitter
//   tx_data    : out DATA_WIDTH            payload to transmitter
//   slot_owner : out ID_WIDTH              node owning the current slot
//   busy       : out 1                     packet buffered or being sent
module photonic_tx_scheduler
  import photonic_pkg::*;
#(
  parameter int ID_WIDTH   = 1,
  parameter int DATA_WIDTH = 1,
  parameter int N_REQ      = 4,
  parameter int SLOT_LEN   = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [ID_WIDTH-1:0]         id,
  input  logic [N_REQ-1:0]            req_valid,
  input  logic [N_REQ*ID_WIDTH-1:0]   req_dest,
  input  logic [N_REQ*DATA_WIDTH-1:0] req_data,
  output logic [N_REQ-1:0]            req_ready,
  output logic                        tx_enable,
  output logic [ID_WIDTH-1:0]         tx_dest_id,
  output logic [DATA_WIDTH-1:0]       tx_data,
  output logic [ID_WIDTH-1:0]         slot_owner,
  output logic                        busy
);

  localparam int PTR_W = $clog2(N_REQ);
  // A one-cycle slot still needs a 1-bit counter so the vector is legal.
  localparam int CNT_W = (SLOT_LEN > 1) ? $clog2(SLOT_LEN) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SLOT_LEN - 1);

  logic [CNT_W-1:0]      cycle_cnt;
  logic [ID_WIDTH-1:0]   next_owner;
  logic                  slot_last;
  logic                  slot_start;

  tx_state_e             state_q;
  tx_state_e             state_d;
  logic [PTR_W-1:0]      rr_ptr;
  logic [PTR_W-1:0]      next_ptr;
  logic [N_REQ-1:0]      grant;
  logic                  found;
  logic                  take;
  logic [ID_WIDTH-1:0]   sel_dest;
  logic [DATA_WIDTH-1:0] sel_data;
  logic [ID_WIDTH-1:0]   buf_dest;
  logic [DATA_WIDTH-1:0] buf_data;

  // The owner increment wraps naturally because NODES is a power of two.
  assign slot_last  = (cycle_cnt == CNT_LAST);
  assign next_owner = slot_owner + ID_WIDTH'(1);
  // True on the last cycle before our own slot, so the edge that ends this
  // cycle is the first edge of our slot.
  assign slot_start = slot_last && (next_owner == id);

  // Slot timer. Every node resets together, so all timers stay aligned.
  always_ff @(posedge clk) begin
    if (!rst) begin
      cycle_cnt  <= '0;
      slot_owner <= '0;
    end else if (slot_last) begin
      cycle_cnt  <= '0;
      slot_owner <= next_owner;
    end else begin
      cycle_cnt  <= cycle_cnt + CNT_W'(1);
    end
  end

  rr_arbiter #(
    .N(N_REQ)
  ) u_arb (
    .valid(req_valid),
    .ptr  (rr_ptr),
    .grant(grant),
    .found(found)
  );

  // Steer the granted requester's fields into the buffer input. The next
  // pointer is the index just after the winner.
  always_comb begin
    sel_dest = '0;
    sel_data = '0;
    next_ptr = rr_ptr;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant[i]) begin
        sel_dest = req_dest[i*ID_WIDTH +: ID_WIDTH];
        sel_data = req_data[i*DATA_WIDTH +: DATA_WIDTH];
        next_ptr = PTR_W'((i + 1) % N_REQ);
      end
    end
  end

  // Next-state and output decode.
  always_comb begin
    state_d    = state_q;
    req_ready  = '0;
    tx_enable  = 1'b0;
    tx_dest_id = '0;
    tx_data    = '0;
    busy       = 1'b0;
    take       = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (found) begin
          req_ready = grant;
          take      = 1'b1;
          state_d   = slot_start ? SEND : WAIT_SLOT;
        end
      end
      WAIT_SLOT: begin
        // A packet accepted partway through our own slot waits a full frame.
        busy = 1'b1;
        if (slot_start) begin
          state_d = SEND;
        end
      end
      SEND: begin
        busy       = 1'b1;
        tx_enable  = 1'b1;
        tx_dest_id = buf_dest;
        tx_data    = buf_data;
        if (slot_last) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // The one-entry packet buffer and the round-robin pointer. Both update
  // only on an accepted grant.
  always_ff @(posedge clk) begin
    if (!rst) begin
      rr_ptr   <= '0;
      buf_dest <= '0;
      buf_data <= '0;
    end else if (take) begin
      rr_ptr   <= next_ptr;
      buf_dest <= sel_dest;
      buf_data <= sel_data;
    end
  end

endmodule

// File: tb/tb_photonic_tx_scheduler.sv
// tb_photonic_tx_scheduler
//   Directed bench for photonic_tx_scheduler with ID_WIDTH=2, DATA_WIDTH=8,
//   N_REQ=4, SLOT_LEN=4 and id=2. Our slot covers cycles 8-11 of each
//   16-cycle frame, where cycle 0 is the first cycle after reset.
module tb_photonic_tx_scheduler;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  id;
  logic [3:0]  req_valid;
  logic [7:0]  req_dest;
  logic [31:0] req_data;
  logic [3:0]  req_ready;
  logic        tx_enable;
  logic [1:0]  tx_dest_id;
  logic [7:0]  tx_data;
  logic [1:0]  slot_owner;
  logic        busy;

  always #5 clk = ~clk;

  photonic_tx_scheduler #(
    .ID_WIDTH  (2),
    .DATA_WIDTH(8),
    .N_REQ     (4),
    .SLOT_LEN  (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .id        (id),
    .req_valid (req_valid),
    .req_dest  (req_dest),
    .req_data  (req_data),
    .req_ready (req_ready),
    .tx_enable (tx_enable),
    .tx_dest_id(tx_dest_id),
    .tx_data   (tx_data),
    .slot_owner(slot_owner),
    .busy      (busy)
  );

  typedef struct {
    logic [3:0] valid;
    logic [3:0] exp_ready;
    logic       exp_en;
    logic [1:0] exp_dest;
    logic [7:0] exp_data;
    logic [1:0] exp_owner;
    logic       exp_busy;
  } vec_t;

  vec_t tbl[14];
  int   vec_count   = 0;
  int   miscompares = 0;

  // Requester fields. Requester 1 targets our own id (self-send).
  logic [1:0] dest_of[4];
  logic [7:0] data_of[4];

  task automatic checkOutput(input string name, input int cyc,
                             input logic [31:0] act, input logic [31:0] exp);
    vec_count++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s @cycle %0d: got %0h, want %0h", name, cyc, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic [3:0] valid);
    req_valid = valid;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Leaves the bench one step into cycle 0, with rst already released.
  task automatic do_reset();
    rst = 1'b0;
    applyStimulus(4'b0000);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  // Index of the requester granted at cycle c in the back-to-back schedule.
  function automatic int grant_slot(input int c);
    case (c)
      0:       return 0;
      12:      return 1;
      28:      return 2;
      44:      return 3;
      default: return -1;
    endcase
  endfunction

  // Single pulse on requester 0 at req_cyc; expects a four-cycle send
  // starting at send_start.
  task automatic run_single(input string tag, input int req_cyc, input int send_start);
    bit en;
    do_reset();
    for (int c = 0; c <= send_start + 5; c++) begin
      applyStimulus((c == req_cyc) ? 4'b0001 : 4'b0000);
      @(negedge clk);
      en = (c >= send_start) && (c < send_start + 4);
      checkOutput({tag, "_ready"}, c, 32'(req_ready), (c == req_cyc) ? 32'h1 : 32'h0);
      checkOutput({tag, "_en"}, c, 32'(tx_enable), 32'(en));
      checkOutput({tag, "_data"}, c, 32'(tx_data), en ? 32'hA5 : 32'h0);
      checkOutput({tag, "_busy"}, c, 32'(busy),
                  32'((c > req_cyc) && (c < send_start + 4)));
      tick();
    end
  endtask

  initial begin
    logic [3:0] hold;
    int         g;
    bit         win;
    int         k;

    id        = 2'd2;
    dest_of   = '{2'd1, 2'd2, 2'd0, 2'd3};
    data_of   = '{8'hA5, 8'h22, 8'h33, 8'h44};
    req_dest  = {dest_of[3], dest_of[2], dest_of[1], dest_of[0]};
    req_data  = {data_of[3], data_of[2], data_of[1], data_of[0]};
    rst       = 1'b0;
    req_valid = 4'b0000;

    // Single request from requester 0 at cycle 0: grant at 0, send 8-11.
    for (int c = 0; c < 14; c++) begin
      tbl[c].valid     = (c == 0) ? 4'b0001 : 4'b0000;
      tbl[c].exp_ready = (c == 0) ? 4'b0001 : 4'b0000;
      tbl[c].exp_en    = (c >= 8) && (c <= 11);
      tbl[c].exp_dest  = tbl[c].exp_en ? 2'd1 : 2'd0;
      tbl[c].exp_data  = tbl[c].exp_en ? 8'hA5 : 8'h00;
      tbl[c].exp_owner = 2'((c / 4) % 4);
      tbl[c].exp_busy  = (c >= 1) && (c <= 11);
    end

    do_reset();
    for (int c = 0; c < 14; c++) begin
      applyStimulus(tbl[c].valid);
      @(negedge clk);
      checkOutput("tbl_ready", c, 32'(req_ready),  32'(tbl[c].exp_ready));
      checkOutput("tbl_en",    c, 32'(tx_enable),  32'(tbl[c].exp_en));
      checkOutput("tbl_dest",  c, 32'(tx_dest_id), 32'(tbl[c].exp_dest));
      checkOutput("tbl_data",  c, 32'(tx_data),    32'(tbl[c].exp_data));
      checkOutput("tbl_owner", c, 32'(slot_owner), 32'(tbl[c].exp_owner));
      checkOutput("tbl_busy",  c, 32'(busy),       32'(tbl[c].exp_busy));
      tick();
    end

    // Request mid own slot waits a full frame; request just before the
    // slot goes straight to SEND.
    run_single("mid", 9, 24);
    run_single("edge", 7, 8);

    // All four requesters valid, each held until granted.
    do_reset();
    hold = 4'b1111;
    for (int c = 0; c < 64; c++) begin
      applyStimulus(hold);
      @(negedge clk);
      g   = grant_slot(c);
      k   = c / 16;
      win = ((c % 16) >= 8) && ((c % 16) <= 11);
      checkOutput("all_ready", c, 32'(req_ready), (g >= 0) ? (32'h1 << g) : 32'h0);
      checkOutput("all_en", c, 32'(tx_enable), 32'(win));
      checkOutput("all_dest", c, 32'(tx_dest_id), win ? 32'(dest_of[k]) : 32'h0);
      checkOutput("all_data", c, 32'(tx_data), win ? 32'(data_of[k]) : 32'h0);
      tick();
      if (g >= 0) hold[g] = 1'b0;
    end

    // Fairness with requesters 0 and 2 held continuously: 0,2,0,2.
    do_reset();
    for (int c = 0; c < 48; c++) begin
      applyStimulus(4'b0101);
      @(negedge clk);
      g = grant_slot(c);
      checkOutput("fair_ready", c, 32'(req_ready),
                  (g < 0) ? 32'h0 : ((g % 2 == 0) ? 32'h1 : 32'h4));
      checkOutput("fair_owner", c, 32'(slot_owner), 32'((c / 4) % 4));
      tick();
    end

    // Reset during SEND drops the packet and restarts the timer.
    do_reset();
    for (int c = 0; c < 10; c++) begin
      applyStimulus((c == 0) ? 4'b0001 : 4'b0000);
      if (c == 9) begin
        @(negedge clk);
        checkOutput("rst_pre_en", c, 32'(tx_enable), 32'h1);
        rst = 1'b0;
      end
      tick();
    end
    rst = 1'b1;
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      checkOutput("rst_en",    c, 32'(tx_enable),  32'h0);
      checkOutput("rst_busy",  c, 32'(busy),       32'h0);
      checkOutput("rst_owner", c, 32'(slot_owner), 32'((c / 4) % 4));
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_count, miscompares);
    $finish;
  end

endmodule

// File: doc/photonic_tx_scheduler.md
# photonic_tx_scheduler

Shares one node's photonic transmitter between `N_REQ` local requesters, such as cores or DMA ports, and places each packet in the node's time-division slot on the shared waveguide. Each node owns one slot per frame and may send at most one packet per slot. The block sits between the requesters and the transmitter half of the transceiver. It drives the transmitter's `enable`, `dest_id` and `data` inputs; the transmitter itself adds the source `id`.

## Interface
Parameters:
- `ID_WIDTH`, default 1: node-id width. Node count `NODES = 2**ID_WIDTH`.
- `DATA_WIDTH`, default 1: payload width.
- `N_REQ`, default 4: number of local requesters. Must be ≥ 2.
- `SLOT_LEN`, default 4: cycles per slot. Must be ≥ 1. Frame length is `NODES*SLOT_LEN` cycles.

Ports:
- `clk`  in  1: single clock, rising edge.
- `rst`  in  1: reset, synchronous and active-low.
- `id`  in  ID_WIDTH: this node's id. Static after reset.
- `req_valid`  in  N_REQ: per-requester packet pending.
- `req_dest`  in  N_REQ*ID_WIDTH: destination id per requester. Requester i occupies slice [i*ID_WIDTH +: ID_WIDTH].
- `req_data`  in  N_REQ*DATA_WIDTH: payload per requester, sliced the same way.
- `req_ready`  out  N_REQ: one-hot or zero; the bit set marks the granted requester this cycle.
- `tx_enable`  out  1: transmitter enable.
- `tx_dest_id`  out  ID_WIDTH: to transmitter `dest_id`.
- `tx_data`  out  DATA_WIDTH: to transmitter `data`.
- `slot_owner`  out  ID_WIDTH: id of the node owning the current slot.
- `busy`  out  1: a packet is buffered or being sent.

## Operation
Slot timer:
- `cycle_cnt` counts 0..SLOT_LEN-1.
- When `cycle_cnt` wraps, `slot_owner` increments modulo `NODES`.
- All nodes share the same reset, so their timers stay aligned.

State machine, states IDLE, WAIT_SLOT and SEND:
- **IDLE**
  - If any `req_valid` bit is set, the round-robin arbiter grants the first valid requester at or after `rr_ptr`.
  - `req_ready[g]` is asserted combinationally for that cycle.
  - The block latches `req_dest[g]` and `req_data[g]` into a one-entry buffer and sets `rr_ptr <= (g+1) mod N_REQ`.
  - Next state is SEND if this edge starts our slot, i.e. `cycle_cnt==SLOT_LEN-1` and `(slot_owner+1) mod NODES == id`. Otherwise next state is WAIT_SLOT.
  - With no request, the block stays in IDLE.
- **WAIT_SLOT**
  - Moves to SEND on the edge that starts our slot (same condition as above).
  - A packet accepted partway through our own slot waits for the next frame; partial slots are never used.
- **SEND**
  - `tx_enable=1` for all `SLOT_LEN` cycles of our slot.
  - `tx_dest_id` and `tx_data` show the buffered values.
  - Moves to IDLE on the edge where `cycle_cnt==SLOT_LEN-1`.
- **Outputs by state**
  - `req_ready` is always 0 outside IDLE.
  - `busy` is 1 in WAIT_SLOT and SEND, 0 in IDLE.
  - `tx_dest_id` and `tx_data` are 0 whenever `tx_enable` is 0.
- **Boundary cases**
  - A packet with `dest==id` (self-send) is sent unchanged.
  - With `SLOT_LEN=1`, `cycle_cnt` stays at 0 and SEND lasts exactly one cycle.
  - `req_valid` may drop without a grant; nothing is latched in that case.

## Timing
Reset (rst=0 at a rising edge):
- Next cycle: state IDLE, `cycle_cnt=0`, `slot_owner=0`, `rr_ptr=0`, buffer cleared.
- All outputs 0, except that `req_ready` may assert combinationally in that same cycle.
- Reset during SEND or WAIT_SLOT drops the buffered packet. `tx_enable` is 0 in the first cycle after the reset edge.

Latency:
- Grant to first `tx_enable` cycle: 1 to `NODES*SLOT_LEN` cycles.
- Maximum throughput: one packet per frame.
- Fairness: with every requester continuously valid, each is granted once every `N_REQ` frames.

## Structure
- Package `photonic_pkg`: holds the state enum (`IDLE`, `WAIT_SLOT`, `SEND`), which the transceiver-level blocks can reuse.
- Sub-module `rr_arbiter #(N)`: combinational, taking `valid` and `ptr` and producing a one-hot `grant` and a `found` flag.
- The top level contains the slot timer, the FSM and the buffer.

## Test plan
All scenarios use `ID_WIDTH=2`, `DATA_WIDTH=8`, `N_REQ=4`, `SLOT_LEN=4`, `id=2`. Cycle 0 is the first cycle after reset deassertion, so our slot is cycles 8–11 of each 16-cycle frame.

- **Single request:** `req_valid[0]` with dest=1, data=0xA5 at cycle 0 → `req_ready[0]` high at cycle 0; `tx_enable` high cycles 8–11 with `tx_dest_id=1`, `tx_data=0xA5`; `busy` low from cycle 12.
- **All four valid from cycle 0, held until granted:** grants go 0,1,2,3 at cycles 0,12,28,44; transmissions at cycles 8, 24, 40, 56.
- **Request at cycle 9 (mid own slot):** granted at cycle 9; `tx_enable` cycles 24–27; cycles 9–11 show `tx_enable=0`.
- **Request at cycle 7 (slot boundary):** FSM goes directly to SEND; `tx_enable` cycles 8–11.
- **Reset mid-send:** rst low at cycle 9 → at cycle 10 `tx_enable=0`, `busy=0`, `slot_owner=0`, `cycle_cnt=0`.
- **Fairness:** `req_valid[0]` and `req_valid[2]` held continuously → grant order 0,2,0,2 with one packet per frame; `slot_owner` wraps 3→0 correctly.
